// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage.
// Holds the FSM state, request-cause codes and lane-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_CONFLICT,
        CAUSE_MISALIGN,
        CAUSE_RANGE
    } cause_t;

    // Number of byte-offset bits in a word of dw bits.
    function automatic int unsigned al_of(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
// The pipeline is the master; the memory stage is the slave.
interface dmem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output wdata,
        input  rdata,
        input  stall,
        input  done,
        input  err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  wdata,
        output rdata,
        output stall,
        output done,
        output err
    );

endinterface

// File: rtl/dmem_array.sv
// Word-wide synchronous storage with a registered read port.
// Contents are deliberately left uninitialised and unaffected by reset.
module dmem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // Write on we and read the addressed word every edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage with configurable latency and stall/done handshake.
// Illegal requests are flagged combinationally and never touch state.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int AL       = int'(al_of(DATA_W));
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_stage: LATENCY must be at least 1");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q;
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;

    cause_t                cause;
    logic                  req;
    logic                  legal;
    logic                  go;
    logic                  enter_done;
    logic                  ld_rdata;
    logic [DEPTH_LOG2-1:0] wix;

    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic [DATA_W-1:0]     arr_wdata;
    logic [DATA_W-1:0]     arr_rdata;

    assign req = bus.mem_read | bus.mem_write;
    assign wix = DEPTH_LOG2'(bus.addr >> AL);

    // Classify the presented request; first matching cause wins.
    always_comb begin
        cause = CAUSE_NONE;
        if (bus.mem_read && bus.mem_write) begin
            cause = CAUSE_CONFLICT;
        end else if (|bus.addr[AL-1:0]) begin
            cause = CAUSE_MISALIGN;
        end else if (|(bus.addr >> (DEPTH_LOG2 + AL))) begin
            cause = CAUSE_RANGE;
        end
    end

    assign legal = (cause == CAUSE_NONE);

    // Next-state, counter and access-edge decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        go         = 1'b0;
        enter_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && legal) begin
                    go = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and load-data registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld_rdata) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    // Capture the request so input changes during BUSY are ignored.
    always_ff @(posedge clk) begin
        if (go) begin
            wr_q    <= bus.mem_write;
            idx_q   <= wix;
            wdata_q <= bus.wdata;
        end
    end

    // In IDLE the live request addresses the array so a one-cycle
    // access can hit the array on the very next edge.
    assign arr_idx   = (state_q == IDLE) ? wix : idx_q;
    assign arr_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
    assign arr_we    = rst && enter_done &&
                       ((state_q == IDLE) ? bus.mem_write : wr_q);

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign ld_rdata  = (state_q == DONE) && !wr_q;

    assign bus.rdata = ld_rdata ? arr_rdata : rdata_q;
    assign bus.done  = (state_q == DONE);
    assign bus.stall = rst && ((go) || (state_q == BUSY));
    assign bus.err   = rst && (state_q == IDLE) && req && !legal;

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage at LATENCY 2 and LATENCY 1.
// Table vectors plus hand sequences for reset and back-to-back cases.
module tb_dmem_stage;

    logic clk;
    logic rst;
    int   ntests;
    int   nfail;

    dmem_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
    dmem_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

    dmem_stage #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(2)
    ) u_l2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    dmem_stage #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)
    ) u_l1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        e;
        logic [15:0] r;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle2();
        b2.mem_read  = 1'b0;
        b2.mem_write = 1'b0;
        b2.addr      = 16'h0000;
        b2.wdata     = 16'h0000;
    endtask

    task automatic idle1();
        b1.mem_read  = 1'b0;
        b1.mem_write = 1'b0;
        b1.addr      = 16'h0000;
        b1.wdata     = 16'h0000;
    endtask

    task automatic txn2(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic e, input logic [15:0] r,
                        input string nm);
        @(negedge clk);
        b2.mem_read  = rd;
        b2.mem_write = wr;
        b2.addr      = a;
        b2.wdata     = d;
        #1;
        if (e) begin
            chk({nm, " err"}, 32'(b2.err), 32'd1);
            chk({nm, " stall"}, 32'(b2.stall), 32'd0);
            chk({nm, " done"}, 32'(b2.done), 32'd0);
            @(negedge clk);
            idle2();
            #1;
            chk({nm, " done after"}, 32'(b2.done), 32'd0);
            chk({nm, " rdata kept"}, 32'(b2.rdata), 32'(r));
        end else begin
            chk({nm, " c0 stall"}, 32'(b2.stall), 32'd1);
            chk({nm, " c0 err"}, 32'(b2.err), 32'd0);
            @(negedge clk);
            #1;
            chk({nm, " c1 stall"}, 32'(b2.stall), 32'd1);
            chk({nm, " c1 done"}, 32'(b2.done), 32'd0);
            @(negedge clk);
            #1;
            chk({nm, " c2 done"}, 32'(b2.done), 32'd1);
            chk({nm, " c2 stall"}, 32'(b2.stall), 32'd0);
            chk({nm, " c2 rdata"}, 32'(b2.rdata), 32'(r));
            idle2();
        end
    endtask

    task automatic wr1(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        b1.mem_write = 1'b1;
        b1.addr      = a;
        b1.wdata     = d;
        #1;
        chk("l1 wr c0 stall", 32'(b1.stall), 32'd1);
        @(negedge clk);
        #1;
        chk("l1 wr c1 done", 32'(b1.done), 32'd1);
        idle1();
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        rst    = 1'b0;
        idle2();
        idle1();

        tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        tbl[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hBEEF};
        tbl[3]  = '{1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0, 16'hBEEF};
        tbl[4]  = '{1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 16'hBEEF};
        tbl[5]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5A5A};
        tbl[6]  = '{1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1, 16'h5A5A};
        tbl[7]  = '{1'b0, 1'b1, 16'h07FE, 16'h0F0F, 1'b0, 16'h5A5A};
        tbl[8]  = '{1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h0F0F};
        tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0F0F};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111};
        tbl[11] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h1111};
        tbl[12] = '{1'b0, 1'b1, 16'h0801, 16'h3333, 1'b1, 16'h1111};
        tbl[13] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        tbl[14] = '{1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0, 16'hBEEF};

        // Reset: outputs forced quiet even with a request present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        b2.mem_read = 1'b1;
        b2.addr     = 16'h0010;
        #1;
        chk("rst stall forced", 32'(b2.stall), 32'd0);
        chk("rst err legal", 32'(b2.err), 32'd0);
        b2.mem_write = 1'b1;
        #1;
        chk("rst err conflict", 32'(b2.err), 32'd0);
        chk("rst rdata", 32'(b2.rdata), 32'd0);
        chk("rst done", 32'(b2.done), 32'd0);
        chk("rst l1 rdata", 32'(b1.rdata), 32'd0);
        idle2();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle stall", 32'(b2.stall), 32'd0);

        for (int i = 0; i < 15; i++) begin
            txn2(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
                 tbl[i].e, tbl[i].r, $sformatf("vec%0d", i));
        end

        // Reset during BUSY aborts the pending write.
        @(negedge clk);
        b2.mem_write = 1'b1;
        b2.addr      = 16'h0030;
        b2.wdata     = 16'hAAAA;
        #1;
        chk("abort c0 stall", 32'(b2.stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle2();
        #1;
        chk("abort busy stall forced", 32'(b2.stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort idle stall", 32'(b2.stall), 32'd0);
        chk("abort done", 32'(b2.done), 32'd0);
        chk("abort rdata", 32'(b2.rdata), 32'd0);
        @(negedge clk);
        #1;
        chk("abort no late done", 32'(b2.done), 32'd0);
        txn2(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5555, "abort readback");

        // Inputs changing during BUSY are ignored.
        txn2(1'b0, 1'b1, 16'h0042, 16'h2222, 1'b0, 16'h5555, "pre 42");
        @(negedge clk);
        b2.mem_write = 1'b1;
        b2.addr      = 16'h0040;
        b2.wdata     = 16'h7777;
        @(negedge clk);
        b2.addr  = 16'h0042;
        b2.wdata = 16'h9999;
        #1;
        chk("hold busy stall", 32'(b2.stall), 32'd1);
        @(negedge clk);
        #1;
        chk("hold done", 32'(b2.done), 32'd1);
        idle2();
        txn2(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h7777, "hold rd 40");
        txn2(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 16'h2222, "hold rd 42");

        // LATENCY 1: back-to-back reads.
        wr1(16'h0004, 16'hA1A1);
        wr1(16'h0006, 16'hB2B2);
        @(negedge clk);
        b1.mem_read = 1'b1;
        b1.addr     = 16'h0004;
        #1;
        chk("l1 c0 stall", 32'(b1.stall), 32'd1);
        chk("l1 c0 done", 32'(b1.done), 32'd0);
        @(negedge clk);
        b1.addr = 16'h0006;
        #1;
        chk("l1 c1 stall", 32'(b1.stall), 32'd0);
        chk("l1 c1 done", 32'(b1.done), 32'd1);
        chk("l1 c1 rdata", 32'(b1.rdata), 32'h0000A1A1);
        @(negedge clk);
        #1;
        chk("l1 c2 stall", 32'(b1.stall), 32'd1);
        chk("l1 c2 done", 32'(b1.done), 32'd0);
        chk("l1 c2 rdata hold", 32'(b1.rdata), 32'h0000A1A1);
        @(negedge clk);
        idle1();
        #1;
        chk("l1 c3 stall", 32'(b1.stall), 32'd0);
        chk("l1 c3 done", 32'(b1.done), 32'd1);
        chk("l1 c3 rdata", 32'(b1.rdata), 32'h0000B2B2);
        @(negedge clk);
        #1;
        chk("l1 c4 done", 32'(b1.done), 32'd0);
        chk("l1 c4 rdata hold", 32'(b1.rdata), 32'h0000B2B2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parametrised data-memory stage for the unpipelined/pipelined processor. It replaces the single-cycle data memory wrapper with one that has a configurable access latency, a stall/done handshake to the pipeline, and error detection for misaligned, out-of-range and conflicting requests. It sits between the execute stage (address = ALU result, write data = second register operand) and write-back (load data).

## Interface
Parameters:
- DATA_W, 16, data word width in bits; multiple of 8, at least 16.
- ADDR_W, 16, byte-address width.
- DEPTH_LOG2, 10, log2 of the number of words stored.
- LATENCY, 2, access latency in cycles; must be at least 1 (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; **synchronous, active-low**.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data; registered.
- stall  out  1  pipeline must hold all inputs stable.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  illegal request flag; combinational.

## Operation
- AL = log2(DATA_W/8). Word index = addr[DEPTH_LOG2+AL-1:AL].
- Request = mem_read | mem_write, evaluated only in IDLE.
- Illegal request conditions:
  - mem_read & mem_write both high (conflict).
  - addr[AL-1:0] != 0 (misaligned).
  - Any addr bit at or above DEPTH_LOG2+AL set (out of range).
- Illegal request response: err=1 and stall=0 in that cycle. No access, no state change, rdata unchanged, done stays 0.
- Legal request: op, word index and wdata are latched.
- FSM states:
  - IDLE, on legal request: to DONE if LATENCY=1, otherwise to BUSY with cnt=LATENCY-2.
  - BUSY: cnt==0 goes to DONE, otherwise cnt decrements.
  - DONE: always returns to IDLE. Inputs are ignored in this cycle because they still carry the completed request.
- Access happens on the edge entering DONE. A write commits to the array at that edge; a read loads rdata from the array at that edge.
- rdata holds its value until the next completed read. Writes and illegal requests never change it.
- Counter width is clog2(LATENCY), minimum 1 bit.

## Timing
- Cycle 0 is the first cycle a legal request is presented in IDLE.
- stall=1 during cycles 0..LATENCY-1.
- In cycle LATENCY: done=1, stall=0, rdata valid for a read. The pipeline advances at the end of that cycle.
- Back-to-back requests: the next request is seen in IDLE at cycle LATENCY+1.
- Throughput is one access per LATENCY+1 cycles.
- Reset values (rst low at an edge): state IDLE, cnt 0, rdata 0, done 0.
- While rst is low, stall=0 and err=0 (forced).
- Array contents are not cleared by reset.
- Reset mid-operation (BUSY, or on the edge that would enter DONE): the pending write is aborted and not committed, rdata becomes 0, and no done pulse occurs.
- Inputs that change during BUSY are ignored. The latched copy is used.

## Structure
- Package dmem_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - the localparam function deriving AL from DATA_W;
  - the illegal-cause encoding used for bench checks.
- Sub-module dmem_array, a synchronous storage array with parameters DATA_W and DEPTH_LOG2. Ports: clk, we, idx, wdata, rdata. Registered read, no reset.
- Top-level dmem_stage contains the FSM, counter, legality check and latch registers.

## Test plan
- LATENCY=2: write 0xBEEF to 0x0010 gives stall 1,1 then done=1 in cycle 2. A following read of 0x0010 gives rdata=0xBEEF with done in cycle 2.
- Read from 0x0011 (misaligned) gives err=1 and stall=0 the same cycle. done stays 0 and rdata keeps its prior value.
- mem_read=mem_write=1 at 0x0020 with wdata 0x1234 gives err=1. A later legal read of 0x0020 returns the earlier stored value, not 0x1234.
- DEPTH_LOG2=10: read at 0x0800 gives err=1. Read at 0x07FE is legal and completes with done after LATENCY cycles.
- Write 0xAAAA to 0x0030 with rst pulled low in a BUSY cycle: next cycle state is IDLE, stall=0, rdata=0, no done. A read of 0x0030 returns the old contents.
- LATENCY=1 with back-to-back legal reads gives stall 1,0,1,0 and done 0,1,0,1. Each rdata matches its address.
